vector_instr_frontend: RTL and testbench
========================================

# vector_instr_frontend

Vector-side receiver for the scalar-to-vector instruction interface: accepts vector instructions plus rs1/rs2 operand values from the scalar core and buffers them in a small FIFO. It presents them to the vector control unit over a valid/ready handshake and back-pressures the scalar core with `vector_stall_o`. It also tracks outstanding vector loads and stores so the scalar core can order its own memory accesses against them. It sits at the entry of `vector_core`, between the scalar core's `v_instruction`/`rs1`/`rs2` outputs and the vector control unit.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of each outstanding load/store counter.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vector_instr_i` in 32: vector instruction from scalar core.
- `rs1_i` in 32: rs1 value sampled with the instruction.
- `rs2_i` in 32: rs2 value sampled with the instruction.
- `instr_valid_i` in 1: scalar core presents an instruction this cycle.
- `vector_stall_o` out 1: frontend cannot accept; scalar core holds the instruction.
- `instr_o` out 32: head instruction to the vector control unit.
- `rs1_o` out 32: head rs1.
- `rs2_o` out 32: head rs2.
- `instr_valid_o` out 1: head entry valid.
- `instr_ready_i` in 1: control unit consumes the head.
- `load_done_i` in 1: pulse, one vector load fully executed.
- `store_done_i` in 1: pulse, one vector store fully executed.
- `all_v_loads_executed_o` out 1: no vector load outstanding.
- `all_v_stores_executed_o` out 1: no vector store outstanding.

## Operation
- Enqueue when `instr_valid_i && !vector_stall_o`: write {instr, rs1, rs2} at the write pointer; pointer advances modulo DEPTH.
- Dequeue when `instr_valid_o && instr_ready_i`: read pointer advances modulo DEPTH.
- Occupancy counter is 0..DEPTH. A simultaneous enqueue and dequeue leaves occupancy unchanged.
- `vector_stall_o` = (occupancy == DEPTH) OR load counter at max OR store counter at max. It depends only on registered state.
- A stall caused by full occupancy is not relieved by a same-cycle dequeue. Acceptance resumes the following cycle.
- Classification happens on enqueue, by `vector_instr_i[6:0]`:
  - 7'b0000111 (LOAD-FP/vector load): load counter +1.
  - 7'b0100111 (vector store): store counter +1.
  - Anything else: no counter change.
- On `load_done_i` / `store_done_i`, the matching counter is decremented by 1.
- Increment and done in the same cycle: the counter is unchanged.
- A done pulse while the counter is 0 is ignored; the counter stays 0 and does not wrap.
- `all_v_loads_executed_o` = (load counter == 0). `all_v_stores_executed_o` = (store counter == 0). Queued-but-undispatched loads and stores count as outstanding.
- The FIFO passes every instruction through unchanged; no decoding beyond the opcode check.

## Timing
- Reset (async assert, sync release): pointers, occupancy and counters are cleared. Outputs are:
  - `vector_stall_o`=0, `instr_valid_o`=0.
  - `instr_o`/`rs1_o`/`rs2_o`=0.
  - `all_v_loads_executed_o`=1, `all_v_stores_executed_o`=1.
- Reset mid-operation discards all queued entries and outstanding counts immediately.
- Latency without bypass: an instruction accepted at edge N gives `instr_valid_o`=1 after edge N, i.e. visible in cycle N+1.
- `instr_valid_o` and the head data stay stable until consumed.
- Executed flags change the cycle after the causing enqueue or done edge.
- Full throughput: one enqueue and one dequeue per cycle.

## Configuration
- `V_FRONTEND_BYPASS_EN` defined: when the FIFO is empty and `instr_valid_i` is high, the inputs drive `instr_o`/`rs1_o`/`rs2_o` combinationally and `instr_valid_o`=1.
  - If `instr_ready_i`=1 in that cycle, the entry is not written and occupancy stays 0. This gives zero-cycle latency.
  - Counters are still updated as for a normal enqueue.
- Not defined: no combinational input-to-output path; minimum latency is 1 cycle as above.

## Test plan
- Reset then idle → `vector_stall_o`=0, `instr_valid_o`=0, both executed flags=1.
- Enqueue 4 instructions (DEPTH=4) with `instr_ready_i`=0 → `vector_stall_o`=1 after the 4th. A 5th presented instruction is not accepted. Raising ready drains them in order, with rs1/rs2 paired correctly.
- Enqueue 0x02006007 (vector load) → `all_v_loads_executed_o`=0 next cycle. `load_done_i` pulse → flag returns to 1. Store flag stays 1 throughout.
- Store enqueue and `store_done_i` in the same cycle with count 1 → count stays 1, flag stays 0. Extra done pulse at count 0 → count stays 0.
- Full FIFO with simultaneous valid-in and dequeue → no enqueue that cycle; the instruction is accepted the next cycle, with no loss and no duplication.
- Assert `reset` mid-stream with 3 entries queued and 2 loads outstanding → immediately `instr_valid_o`=0 and `all_v_loads_executed_o`=1. With `V_FRONTEND_BYPASS_EN` and an empty FIFO, `instr_o` equals `vector_instr_i` in the same cycle.

Source files
------------

// File: rtl/vector_instr_frontend_if.sv
// ---------------------------------------------------------------------------
// vector_instr_frontend_if
//
// Bundles the scalar-to-vector instruction path, the control-unit handshake
// and the load/store completion tracking used by vector_instr_frontend.
//
// Signals (named from the frontend's point of view):
//   vector_instr_i, rs1_i, rs2_i : instruction and operands from scalar core
//   instr_valid_i                : scalar core presents an instruction
//   vector_stall_o               : frontend cannot accept this cycle
//   instr_o, rs1_o, rs2_o        : head entry to the vector control unit
//   instr_valid_o / instr_ready_i: head handshake with the control unit
//   load_done_i / store_done_i   : one vector load / store fully executed
//   all_v_loads_executed_o       : no vector load outstanding
//   all_v_stores_executed_o      : no vector store outstanding
//
// Modports:
//   master : the surrounding system (scalar core + vector control unit)
//   slave  : the frontend itself
// ---------------------------------------------------------------------------
interface vector_instr_frontend_if;
    logic [31:0] vector_instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        instr_valid_i;
    logic        vector_stall_o;
    logic [31:0] instr_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        load_done_i;
    logic        store_done_i;
    logic        all_v_loads_executed_o;
    logic        all_v_stores_executed_o;

    modport master (
        output vector_instr_i, rs1_i, rs2_i, instr_valid_i,
        output instr_ready_i, load_done_i, store_done_i,
        input  vector_stall_o, instr_o, rs1_o, rs2_o, instr_valid_o,
        input  all_v_loads_executed_o, all_v_stores_executed_o
    );

    modport slave (
        input  vector_instr_i, rs1_i, rs2_i, instr_valid_i,
        input  instr_ready_i, load_done_i, store_done_i,
        output vector_stall_o, instr_o, rs1_o, rs2_o, instr_valid_o,
        output all_v_loads_executed_o, all_v_stores_executed_o
    );
endinterface

// File: rtl/vector_instr_frontend.sv
// ---------------------------------------------------------------------------
// vector_instr_frontend
//
// Receives vector instructions with their rs1/rs2 values from the scalar
// core, buffers them in a DEPTH-entry FIFO and presents them to the vector
// control unit over a valid/ready handshake. Also counts outstanding vector
// loads and stores (counted at enqueue, retired by done pulses) so the
// scalar core can order its own memory accesses against them.
//
// Parameters:
//   DEPTH : FIFO entries, power of two, >= 2
//   CNT_W : width of each outstanding load/store counter
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : vector_instr_frontend_if.slave (see interface file for signals)
//
// Configuration macro:
//   V_FRONTEND_BYPASS_EN : when defined, an instruction arriving at an empty
//                          FIFO is presented combinationally on the output
//                          and is not written if consumed in the same cycle.
// ---------------------------------------------------------------------------
module vector_instr_frontend #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    vector_instr_frontend_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [6:0]       OP_V_LOAD  = 7'b0000111;
    localparam logic [6:0]       OP_V_STORE = 7'b0100111;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_rs1   [DEPTH];
    logic [31:0] mem_rs2   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    logic fifo_empty;
    logic fifo_full;
    logic stall;
    logic accept;
    logic bypass_take;
    logic write_en;
    logic fifo_deq;
    logic load_inc;
    logic store_inc;

    logic [31:0] head_instr;
    logic [31:0] head_rs1;
    logic [31:0] head_rs2;
    logic        head_valid;

    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == OCC_W'(DEPTH));

    // Stall looks only at registered state, so a same-cycle dequeue does not
    // reopen a full FIFO; acceptance resumes on the following cycle.
    assign stall  = fifo_full || (load_cnt == CNT_MAX) || (store_cnt == CNT_MAX);
    assign accept = bus.instr_valid_i && !stall;

    assign load_inc  = accept && (bus.vector_instr_i[6:0] == OP_V_LOAD);
    assign store_inc = accept && (bus.vector_instr_i[6:0] == OP_V_STORE);

`ifdef V_FRONTEND_BYPASS_EN
    // Bypass only forwards an instruction that is actually being accepted;
    // a counter-saturation stall must not leak an unaccepted instruction.
    logic bypass_active;
    assign bypass_active = fifo_empty && accept;
    assign bypass_take   = bypass_active && bus.instr_ready_i;
`else
    assign bypass_take   = 1'b0;
`endif

    // A bypassed-and-consumed instruction never touches the storage.
    assign write_en = accept && !bypass_take;
    assign fifo_deq = !fifo_empty && bus.instr_ready_i;

    // Head presentation; data is forced to zero while the FIFO is empty so
    // the outputs are clean after reset.
    always_comb begin
        head_valid = !fifo_empty;
        head_instr = fifo_empty ? 32'h0 : mem_instr[rd_ptr];
        head_rs1   = fifo_empty ? 32'h0 : mem_rs1[rd_ptr];
        head_rs2   = fifo_empty ? 32'h0 : mem_rs2[rd_ptr];
`ifdef V_FRONTEND_BYPASS_EN
        if (bypass_active) begin
            head_valid = 1'b1;
            head_instr = bus.vector_instr_i;
            head_rs1   = bus.rs1_i;
            head_rs2   = bus.rs2_i;
        end
`endif
    end

    // Entry storage needs no reset: it is only observed through the
    // occupancy-qualified head logic above.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_instr[wr_ptr] <= bus.vector_instr_i;
            mem_rs1[wr_ptr]   <= bus.rs1_i;
            mem_rs2[wr_ptr]   <= bus.rs2_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({write_en, fifo_deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Outstanding counters: increment and done together cancel out, and a
    // done at zero is dropped rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (load_inc && !bus.load_done_i) begin
                load_cnt <= load_cnt + CNT_W'(1);
            end else if (!load_inc && bus.load_done_i && (load_cnt != '0)) begin
                load_cnt <= load_cnt - CNT_W'(1);
            end

            if (store_inc && !bus.store_done_i) begin
                store_cnt <= store_cnt + CNT_W'(1);
            end else if (!store_inc && bus.store_done_i && (store_cnt != '0)) begin
                store_cnt <= store_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.vector_stall_o          = stall;
    assign bus.instr_valid_o           = head_valid;
    assign bus.instr_o                 = head_instr;
    assign bus.rs1_o                   = head_rs1;
    assign bus.rs2_o                   = head_rs2;
    assign bus.all_v_loads_executed_o  = (load_cnt == '0);
    assign bus.all_v_stores_executed_o = (store_cnt == '0);

endmodule

// File: tb/tb_vector_instr_frontend.sv
// ---------------------------------------------------------------------------
// tb_vector_instr_frontend
//
// Drives vector_instr_frontend (DEPTH=4, CNT_W=3 so counter saturation is
// reachable) with directed sequences and random traffic. A queue-based model
// of the instruction stream and two integer counters predict every output;
// a negedge process compares them each cycle, and literal checks pin the
// model at key points.
// ---------------------------------------------------------------------------
module tb_vector_instr_frontend;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000111;
    localparam logic [6:0] OP_STORE = 7'b0100111;
    localparam logic [6:0] OP_ARITH = 7'b1010111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cmp_en = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vector_instr_frontend_if bus();

    vector_instr_frontend #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    entry_t model_q[$];
    int     model_loads  = 0;
    int     model_stores = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic valid,
                                 input logic ready, input logic ld, input logic sd);
        @(posedge clk);
        #1;
        bus.vector_instr_i = instr;
        bus.rs1_i          = r1;
        bus.rs2_i          = r2;
        bus.instr_valid_i  = valid;
        bus.instr_ready_i  = ready;
        bus.load_done_i    = ld;
        bus.store_done_i   = sd;
    endtask

    task automatic driveIdle();
        bus.vector_instr_i = 32'h0;
        bus.rs1_i          = 32'h0;
        bus.rs2_i          = 32'h0;
        bus.instr_valid_i  = 1'b0;
        bus.instr_ready_i  = 1'b0;
        bus.load_done_i    = 1'b0;
        bus.store_done_i   = 1'b0;
    endtask

    function automatic logic model_stall();
        return (model_q.size() == DEPTH) || (model_loads == CNT_MAX) ||
               (model_stores == CNT_MAX);
    endfunction

    function automatic logic model_bypass();
`ifdef V_FRONTEND_BYPASS_EN
        return (model_q.size() == 0) && bus.instr_valid_i && !model_stall();
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_valid();
        return model_bypass() || (model_q.size() != 0);
    endfunction

    // Model advance: what the stream and counters become after each edge.
    always @(posedge clk or posedge reset) begin
        logic acc;
        logic byp;
        logic deq;
        logic li;
        logic si;
        if (reset) begin
            model_q.delete();
            model_loads  = 0;
            model_stores = 0;
        end else begin
            acc = bus.instr_valid_i && !model_stall();
            byp = model_bypass();
            deq = model_valid() && bus.instr_ready_i;
            li  = acc && (bus.vector_instr_i[6:0] == OP_LOAD);
            si  = acc && (bus.vector_instr_i[6:0] == OP_STORE);
            if (deq && !byp) begin
                void'(model_q.pop_front());
            end
            if (acc && !(byp && deq)) begin
                model_q.push_back('{instr: bus.vector_instr_i, rs1: bus.rs1_i,
                                    rs2: bus.rs2_i});
            end
            if (li && !bus.load_done_i)                            model_loads++;
            else if (!li && bus.load_done_i && model_loads > 0)   model_loads--;
            if (si && !bus.store_done_i)                           model_stores++;
            else if (!si && bus.store_done_i && model_stores > 0) model_stores--;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] e_instr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        if (cmp_en) begin
            checkOutput("stall", bus.vector_stall_o, model_stall());
            checkOutput("valid", bus.instr_valid_o, model_valid());
            checkOutput("loads_flag", bus.all_v_loads_executed_o, model_loads == 0);
            checkOutput("stores_flag", bus.all_v_stores_executed_o, model_stores == 0);
            if (model_valid()) begin
                if (model_bypass()) begin
                    e_instr = bus.vector_instr_i;
                    e_rs1   = bus.rs1_i;
                    e_rs2   = bus.rs2_i;
                end else begin
                    e_instr = model_q[0].instr;
                    e_rs1   = model_q[0].rs1;
                    e_rs2   = model_q[0].rs2;
                end
                checkOutput("head_instr", bus.instr_o, e_instr);
                checkOutput("head_rs1", bus.rs1_o, e_rs1);
                checkOutput("head_rs2", bus.rs2_o, e_rs2);
            end
        end
    end

    initial begin
        logic [31:0] instr;
        logic [6:0]  op;
        driveIdle();
        reset = 1'b1;
        #1;
        cmp_en = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", bus.vector_stall_o, 1'b0);
        checkOutput("reset_valid", bus.instr_valid_o, 1'b0);
        checkOutput("reset_instr", bus.instr_o, 32'h0);
        checkOutput("reset_rs1", bus.rs1_o, 32'h0);
        checkOutput("reset_rs2", bus.rs2_o, 32'h0);
        checkOutput("reset_loads_flag", bus.all_v_loads_executed_o, 1'b1);
        checkOutput("reset_stores_flag", bus.all_v_stores_executed_o, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle_stall", bus.vector_stall_o, 1'b0);
        checkOutput("idle_valid", bus.instr_valid_o, 1'b0);

        // Fill to DEPTH with ready low, then hold a 5th instruction
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'h1000_0057 | (i << 8), 32'hA000_0000 + i,
                          32'hB000_0000 + i, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(32'h1000_0457, 32'hA000_0004, 32'hB000_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_stall", bus.vector_stall_o, 1'b1);
        checkOutput("full_head_instr", bus.instr_o, 32'h1000_0057);
        checkOutput("full_head_rs2", bus.rs2_o, 32'hB000_0000);
        applyStimulus(32'h1000_0457, 32'hA000_0004, 32'hB000_0004, 1'b1, 1'b0, 1'b0, 1'b0);

        // Dequeue while full: no enqueue this cycle, accepted the next
        applyStimulus(32'h1000_0457, 32'hA000_0004, 32'hB000_0004, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_with_deq", bus.vector_stall_o, 1'b1);
        applyStimulus(32'h1000_0457, 32'hA000_0004, 32'hB000_0004, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("resume_stall", bus.vector_stall_o, 1'b0);
        checkOutput("second_head_instr", bus.instr_o, 32'h1000_0157);
        checkOutput("second_head_rs1", bus.rs1_o, 32'hA000_0001);
        repeat (3) applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("last_head_instr", bus.instr_o, 32'h1000_0457);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drained_valid", bus.instr_valid_o, 1'b0);

        // Vector load tracking
        applyStimulus(32'h0200_6007, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load_flag_set", bus.all_v_loads_executed_o, 1'b0);
        checkOutput("store_flag_on_load", bus.all_v_stores_executed_o, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("load_flag_at_done", bus.all_v_loads_executed_o, 1'b0);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load_flag_clear", bus.all_v_loads_executed_o, 1'b1);
        checkOutput("store_flag_after_load", bus.all_v_stores_executed_o, 1'b1);

        // Store enqueue and done together, then extra done at zero
        applyStimulus(32'h0200_6027, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0200_6027, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("store_flag_hold", bus.all_v_stores_executed_o, 1'b0);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("store_flag_clear", bus.all_v_stores_executed_o, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("store_flag_zero", bus.all_v_stores_executed_o, 1'b1);
        checkOutput("store_no_wrap_stall", bus.vector_stall_o, 1'b0);

        // Load counter saturation stalls the frontend
        for (int i = 0; i < CNT_MAX; i++) begin
            applyStimulus(32'h0000_0007 | (i << 12), 32'h10 + i, 32'h20 + i,
                          1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(32'h0000_F007, 32'h99, 32'h98, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load_max_stall", bus.vector_stall_o, 1'b1);
        for (int i = 0; i < CNT_MAX; i++) begin
            applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load_max_drained", bus.all_v_loads_executed_o, 1'b1);
        checkOutput("load_max_unstall", bus.vector_stall_o, 1'b0);

        // Reset mid-stream with 3 queued entries, 2 of them loads
        applyStimulus(32'h0000_1007, 32'h31, 32'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_2057, 32'h32, 32'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_3007, 32'h33, 32'h43, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        driveIdle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", bus.instr_valid_o, 1'b0);
        checkOutput("midrst_loads_flag", bus.all_v_loads_executed_o, 1'b1);
        checkOutput("midrst_stall", bus.vector_stall_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(32'hCAFE_0057, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef V_FRONTEND_BYPASS_EN
        checkOutput("bypass_valid", bus.instr_valid_o, 1'b1);
        checkOutput("bypass_instr", bus.instr_o, 32'hCAFE_0057);
`else
        checkOutput("no_bypass_valid", bus.instr_valid_o, 1'b0);
`endif
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_head", bus.instr_o, 32'hCAFE_0057);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                default: op = OP_ARITH;
            endcase
            instr = {$urandom() & 32'hFFFF_FF80} | {25'h0, op};
            applyStimulus(instr, $urandom(), $urandom(),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
        end

        // Drain everything and retire all outstanding work
        for (int n = 0; n < 20; n++) begin
            applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("final_valid", bus.instr_valid_o, 1'b0);
        checkOutput("final_loads_flag", bus.all_v_loads_executed_o, 1'b1);
        checkOutput("final_stores_flag", bus.all_v_stores_executed_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
